// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: bus widths, reset and
// write-enable encodings, and the arbiter state encoding.
package wb_port_arbiter_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  localparam reg_addr_t NOP_REG_ADDR  = 5'd0;
  localparam reg_data_t ZERO_WORD     = 32'h0000_0000;
  localparam logic      WRITE_ENABLE  = 1'b1;
  localparam logic      WRITE_DISABLE = 1'b0;
  localparam logic      RST_ENABLE    = 1'b1;

  typedef enum logic [1:0] {
    WB_ARB_IDLE  = 2'd0,
    WB_ARB_PEND  = 2'd1,
    WB_ARB_FORCE = 2'd2
  } wb_arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline / multi-cycle unit (master) and the
// write-back port arbiter (slave).
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  reg_addr_t ex_wd;
  logic      ex_wreg;
  reg_data_t ex_wdata;
  logic      mc_valid;
  reg_addr_t mc_wd;
  reg_data_t mc_wdata;
  logic      mc_ready;
  logic      stall_req;
  reg_addr_t wb_wd;
  logic      wb_wreg;
  reg_data_t wb_wdata;

  modport master (
    output ex_wd, ex_wreg, ex_wdata, mc_valid, mc_wd, mc_wdata,
    input  mc_ready, stall_req, wb_wd, wb_wreg, wb_wdata
  );

  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, mc_valid, mc_wd, mc_wdata,
    output mc_ready, stall_req, wb_wd, wb_wreg, wb_wdata
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// Pending multi-cycle result buffer. Each entry carries a live bit; an entry
// whose register was overwritten by a newer EX result is killed by address
// and later popped without using the write port.
module wb_pend_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  reg_addr_t     push_wd,
  input  reg_data_t     push_wdata,
  input  logic          pop,
  input  logic          kill_en,
  input  reg_addr_t     kill_wd,
  output logic          head_live,
  output reg_addr_t     head_wd,
  output reg_data_t     head_wdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  reg_addr_t        wd_r    [DEPTH];
  reg_data_t        wdata_r [DEPTH];
  logic [DEPTH-1:0] live_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;

  // Entry storage, live bits, pointers and occupancy; a same-cycle push wins
  // over the kill so a freshly accepted result always starts live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) begin
        wd_r[i]    <= NOP_REG_ADDR;
        wdata_r[i] <= ZERO_WORD;
      end
      live_r   <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && live_r[i] && (wd_r[i] == kill_wd)) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop) begin
        live_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r         <= rd_ptr_r + PW'(1);
      end
      if (push) begin
        wd_r[wr_ptr_r]    <= push_wd;
        wdata_r[wr_ptr_r] <= push_wdata;
        live_r[wr_ptr_r]  <= 1'b1;
        wr_ptr_r          <= wr_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign empty      = (count_r == '0);
  assign full       = (count_r == CW'(DEPTH));
  assign count      = count_r;
  assign head_live  = !empty && live_r[rd_ptr_r];
  assign head_wd    = wd_r[rd_ptr_r];
  assign head_wdata = wdata_r[rd_ptr_r];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between EX write-back and buffered
// multi-cycle results. EX normally wins; a starving buffered result forces a
// one-cycle pipeline stall so it can drain.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  wb_arb_state_e state_r, state_next_s;
  logic [SW-1:0] starve_r, starve_next_s;
  logic          push_s, pop_s, ex_grant_s, head_loss_s;
  logic          head_live_s, full_s, empty_s;
  reg_addr_t     head_wd_s;
  reg_data_t     head_wdata_s;
  logic [CW-1:0] count_s, count_next_s;
  logic          grant_wreg_s;
  reg_addr_t     grant_wd_s;
  reg_data_t     grant_wdata_s;
  logic          wb_wreg_r, stall_r;
  reg_addr_t     wb_wd_r;
  reg_data_t     wb_wdata_r;

  // r0 results are accepted but never stored since they cannot be written.
  assign push_s       = bus.mc_valid && !full_s && (bus.mc_wd != NOP_REG_ADDR);
  assign count_next_s = count_s + CW'(push_s) - CW'(pop_s);

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_wd    (bus.mc_wd),
    .push_wdata (bus.mc_wdata),
    .pop        (pop_s),
    .kill_en    (ex_grant_s),
    .kill_wd    (bus.ex_wd),
    .head_live  (head_live_s),
    .head_wd    (head_wd_s),
    .head_wdata (head_wdata_s),
    .count      (count_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Grant mux: FORCE drains the head, else EX, else a live head; dead heads pop silently.
  always_comb begin
    grant_wreg_s  = WRITE_DISABLE;
    grant_wd_s    = NOP_REG_ADDR;
    grant_wdata_s = ZERO_WORD;
    pop_s         = 1'b0;
    ex_grant_s    = 1'b0;
    head_loss_s   = 1'b0;
    if (state_r == WB_ARB_FORCE) begin
      pop_s = !empty_s;
      if (head_live_s) begin
        grant_wreg_s  = WRITE_ENABLE;
        grant_wd_s    = head_wd_s;
        grant_wdata_s = head_wdata_s;
      end else begin
        grant_wreg_s  = WRITE_DISABLE;
      end
    end else if (bus.ex_wreg == WRITE_ENABLE) begin
      ex_grant_s    = 1'b1;
      grant_wreg_s  = WRITE_ENABLE;
      grant_wd_s    = bus.ex_wd;
      grant_wdata_s = bus.ex_wdata;
      if (head_live_s) begin
        head_loss_s = 1'b1;
      end else begin
        pop_s = !empty_s;
      end
    end else if (head_live_s) begin
      pop_s         = 1'b1;
      grant_wreg_s  = WRITE_ENABLE;
      grant_wd_s    = head_wd_s;
      grant_wdata_s = head_wdata_s;
    end else begin
      pop_s = !empty_s;
    end
  end

  // Next state and starvation count: too many losses for the head schedule a FORCE cycle.
  always_comb begin
    state_next_s  = state_r;
    starve_next_s = starve_r;
    case (state_r)
      WB_ARB_FORCE: begin
        starve_next_s = '0;
        state_next_s  = (count_next_s != '0) ? WB_ARB_PEND : WB_ARB_IDLE;
      end
      WB_ARB_IDLE, WB_ARB_PEND: begin
        if (head_loss_s && (starve_r == STARVE_MAX)) begin
          state_next_s  = WB_ARB_FORCE;
          starve_next_s = '0;
        end else begin
          state_next_s = (count_next_s != '0) ? WB_ARB_PEND : WB_ARB_IDLE;
          if (pop_s) begin
            starve_next_s = '0;
          end else if (head_loss_s) begin
            starve_next_s = starve_r + SW'(1);
          end else begin
            starve_next_s = starve_r;
          end
        end
      end
      default: begin
        state_next_s  = WB_ARB_IDLE;
        starve_next_s = '0;
      end
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_r  <= WB_ARB_IDLE;
      starve_r <= '0;
    end else begin
      state_r  <= state_next_s;
      starve_r <= starve_next_s;
    end
  end

  // Registered write port and stall request (stall is high for the whole FORCE cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      wb_wreg_r  <= WRITE_DISABLE;
      wb_wd_r    <= NOP_REG_ADDR;
      wb_wdata_r <= ZERO_WORD;
      stall_r    <= 1'b0;
    end else begin
      wb_wreg_r  <= grant_wreg_s;
      wb_wd_r    <= grant_wd_s;
      wb_wdata_r <= grant_wdata_s;
      stall_r    <= (state_next_s == WB_ARB_FORCE);
    end
  end

  assign bus.wb_wreg   = wb_wreg_r;
  assign bus.wb_wd     = wb_wd_r;
  assign bus.wb_wdata  = wb_wdata_r;
  assign bus.stall_req = stall_r;
  assign bus.mc_ready  = !full_s;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, reset
// corner case, then randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  wd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  int          losses;
  bit          force_now;
  logic        exp_wreg;
  logic [4:0]  exp_wd;
  logic [31:0] exp_wdata;

  task automatic model_reset();
    q.delete();
    losses    = 0;
    force_now = 0;
    exp_wreg  = 1'b0;
    exp_wd    = 5'd0;
    exp_wdata = 32'd0;
  endtask

  // One clock edge of the arbiter, described as queue operations.
  task automatic model_step();
    bit   accept;
    bit   has_head;
    bit   head_live;
    ent_t e;
    accept    = bus.mc_valid && (q.size() < DEPTH);
    has_head  = (q.size() > 0);
    head_live = has_head && q[0].live;
    exp_wreg  = 1'b0;
    exp_wd    = 5'd0;
    exp_wdata = 32'd0;
    if (force_now) begin
      force_now = 0;
      losses    = 0;
      if (has_head) begin
        if (head_live) begin
          exp_wreg = 1'b1; exp_wd = q[0].wd; exp_wdata = q[0].data;
        end
        void'(q.pop_front());
      end
    end else if (bus.ex_wreg) begin
      exp_wreg = 1'b1; exp_wd = bus.ex_wd; exp_wdata = bus.ex_wdata;
      foreach (q[i]) if (q[i].wd == bus.ex_wd) q[i].live = 0;
      if (head_live) begin
        losses++;
        if (losses == STARVE_LIMIT) begin
          force_now = 1;
          losses    = 0;
        end
      end else if (has_head) begin
        void'(q.pop_front());
        losses = 0;
      end
    end else if (has_head) begin
      if (head_live) begin
        exp_wreg = 1'b1; exp_wd = q[0].wd; exp_wdata = q[0].data;
      end
      void'(q.pop_front());
      losses = 0;
    end
    if (accept && (bus.mc_wd != 5'd0)) begin
      e.wd = bus.mc_wd; e.data = bus.mc_wdata; e.live = 1;
      q.push_back(e);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic exw, input logic [4:0] exwd, input logic [31:0] exd,
                       input logic mcv, input logic [4:0] mcwd, input logic [31:0] mcd);
    bus.ex_wreg = exw; bus.ex_wd = exwd; bus.ex_wdata = exd;
    bus.mc_valid = mcv; bus.mc_wd = mcwd; bus.mc_wdata = mcd;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".wb_wreg"},   32'(bus.wb_wreg),   32'd0);
    check({tag, ".wb_wd"},     32'(bus.wb_wd),     32'd0);
    check({tag, ".wb_wdata"},  bus.wb_wdata,       32'd0);
    check({tag, ".stall_req"}, 32'(bus.stall_req), 32'd0);
    check({tag, ".mc_ready"},  32'(bus.mc_ready),  32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ex_wreg;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata;
    logic        mc_valid;
    logic [4:0]  mc_wd;
    logic [31:0] mc_wdata;
    logic        e_wreg;
    logic [4:0]  e_wd;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_ready;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  task automatic set_vec(input int i,
                         input logic exw, input logic [4:0] exwd, input logic [31:0] exd,
                         input logic mcv, input logic [4:0] mcwd, input logic [31:0] mcd,
                         input logic ew, input logic [4:0] ewd, input logic [31:0] ed,
                         input logic es, input logic er);
    vecs[i] = '{exw, exwd, exd, mcv, mcwd, mcd, ew, ewd, ed, es, er};
  endtask

  initial begin
    // idle drain
    set_vec( 0, 1'b0, 5'd0, 32'd0,  1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,        1'b0, 1'b1);
    set_vec( 1, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    set_vec( 2, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 1'b1);
    // r0 discard
    set_vec( 3, 1'b0, 5'd0, 32'd0,  1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'd0,        1'b0, 1'b1);
    set_vec( 4, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 1'b1);
    // starvation: four losses, FORCE, then EX re-presented
    set_vec( 5, 1'b1, 5'd3, 32'd33, 1'b1, 5'd7, 32'd77,       1'b1, 5'd3, 32'd33,       1'b0, 1'b1);
    set_vec( 6, 1'b1, 5'd3, 32'd34, 1'b0, 5'd0, 32'd0,        1'b1, 5'd3, 32'd34,       1'b0, 1'b1);
    set_vec( 7, 1'b1, 5'd3, 32'd35, 1'b0, 5'd0, 32'd0,        1'b1, 5'd3, 32'd35,       1'b0, 1'b1);
    set_vec( 8, 1'b1, 5'd3, 32'd36, 1'b0, 5'd0, 32'd0,        1'b1, 5'd3, 32'd36,       1'b0, 1'b1);
    set_vec( 9, 1'b1, 5'd3, 32'd37, 1'b0, 5'd0, 32'd0,        1'b1, 5'd3, 32'd37,       1'b1, 1'b1);
    set_vec(10, 1'b1, 5'd3, 32'd38, 1'b0, 5'd0, 32'd0,        1'b1, 5'd7, 32'd77,       1'b0, 1'b1);
    set_vec(11, 1'b1, 5'd3, 32'd38, 1'b0, 5'd0, 32'd0,        1'b1, 5'd3, 32'd38,       1'b0, 1'b1);
    set_vec(12, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 1'b1);
    // WAW kill
    set_vec(13, 1'b1, 5'd4, 32'd44, 1'b1, 5'd9, 32'hAAAA,     1'b1, 5'd4, 32'd44,       1'b0, 1'b1);
    set_vec(14, 1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0,      1'b1, 5'd9, 32'hBBBB,     1'b0, 1'b1);
    set_vec(15, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 1'b1);
    set_vec(16, 1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,        1'b0, 1'b1);
    // full buffer, held third result, forced drain
    set_vec(17, 1'b1, 5'd3, 32'd1,  1'b1, 5'd1, 32'hD1,       1'b1, 5'd3, 32'd1,        1'b0, 1'b1);
    set_vec(18, 1'b1, 5'd3, 32'd2,  1'b1, 5'd2, 32'hD2,       1'b1, 5'd3, 32'd2,        1'b0, 1'b0);
    set_vec(19, 1'b1, 5'd3, 32'd3,  1'b1, 5'd3, 32'hD3,       1'b1, 5'd3, 32'd3,        1'b0, 1'b0);
    set_vec(20, 1'b1, 5'd3, 32'd4,  1'b1, 5'd3, 32'hD3,       1'b1, 5'd3, 32'd4,        1'b0, 1'b0);
    set_vec(21, 1'b1, 5'd3, 32'd5,  1'b1, 5'd3, 32'hD3,       1'b1, 5'd3, 32'd5,        1'b1, 1'b0);
    set_vec(22, 1'b1, 5'd3, 32'd6,  1'b1, 5'd3, 32'hD3,       1'b1, 5'd1, 32'hD1,       1'b0, 1'b1);
    set_vec(23, 1'b1, 5'd3, 32'd6,  1'b1, 5'd3, 32'hD3,       1'b1, 5'd3, 32'd6,        1'b0, 1'b0);

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    model_reset();
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ex_wreg, vecs[i].ex_wd, vecs[i].ex_wdata,
            vecs[i].mc_valid, vecs[i].mc_wd, vecs[i].mc_wdata);
      step();
      check($sformatf("vec%0d.wb_wreg", i),   32'(bus.wb_wreg),   32'(vecs[i].e_wreg));
      check($sformatf("vec%0d.wb_wd", i),     32'(bus.wb_wd),     32'(vecs[i].e_wd));
      check($sformatf("vec%0d.wb_wdata", i),  bus.wb_wdata,       vecs[i].e_wdata);
      check($sformatf("vec%0d.stall_req", i), 32'(bus.stall_req), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d.mc_ready", i),  32'(bus.mc_ready),  32'(vecs[i].e_ready));
    end

    // Reset mid-operation with two entries buffered: pending results are discarded.
    drive(1'b1, 5'd3, 32'd6, 1'b0, 5'd0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle_outputs($sformatf("postreset%0d", i));
    end

    // Randomized traffic against the reference model; a stalled pipeline holds EX.
    for (int c = 0; c < 800; c++) begin
      if (bus.stall_req == 1'b0) begin
        bus.ex_wreg  = ($urandom_range(0, 3) != 0);
        bus.ex_wd    = 5'($urandom_range(0, 7));
        bus.ex_wdata = $urandom;
      end
      bus.mc_valid = ($urandom_range(0, 2) == 0);
      bus.mc_wd    = 5'($urandom_range(0, 7));
      bus.mc_wdata = $urandom;
      step();
      check("rand.wb_wreg",   32'(bus.wb_wreg),   32'(exp_wreg));
      check("rand.wb_wd",     32'(bus.wb_wd),     32'(exp_wd));
      check("rand.wb_wdata",  bus.wb_wdata,       exp_wdata);
      check("rand.stall_req", 32'(bus.stall_req), 32'(force_now));
      check("rand.mc_ready",  32'(bus.mc_ready),  32'(q.size() < DEPTH));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
